// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/capture stage: opcodes, FSM states
// and the opcode-to-latency rule used by the decoder.
package alu_issue_ctrl_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_SHR = 5'd4;
    localparam logic [4:0] OP_SHL = 5'd5;
    localparam logic [4:0] OP_ROR = 5'd6;
    localparam logic [4:0] OP_ROL = 5'd7;
    localparam logic [4:0] OP_AND = 5'd8;
    localparam logic [4:0] OP_OR  = 5'd9;
    localparam logic [4:0] OP_NEG = 5'd10;
    localparam logic [4:0] OP_NOT = 5'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Only the clocked multiplier needs extra cycles; everything else settles
    // within the single EXEC cycle.
    function automatic int op_latency(input logic [4:0] op, input int mul_latency);
        return (op == OP_MUL) ? mul_latency : 0;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational request screen: flags illegal opcodes and divide-by-zero and
// reports how many extra EXEC cycles a legal op needs.
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int MUL_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] b_in,
    output logic             legal,
    output logic             div_by_zero,
    output logic [CNT_W-1:0] latency
);

    assign legal       = (op <= OP_NOT);
    assign div_by_zero = (op == OP_DIV) && (b_in == '0);
    assign latency     = CNT_W'(op_latency(op, MUL_LATENCY));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage around the ALU: accepts one request, holds it on the
// ALU inputs for its latency, captures the Z pair and pulses done.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int MUL_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic             z_zero,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_ctrl,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_zhi,
    input  logic [WIDTH-1:0] alu_zlo
);

    state_t           state, state_nxt;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CNT_W-1:0] cnt_q;

    logic             legal, div_by_zero;
    logic [CNT_W-1:0] latency;
    logic             accept, capture, raise_err, cnt_dec;

    alu_op_decode #(
        .WIDTH       (WIDTH),
        .MUL_LATENCY (MUL_LATENCY),
        .CNT_W       (CNT_W)
    ) u_decode (
        .op          (op),
        .b_in        (b_in),
        .legal       (legal),
        .div_by_zero (div_by_zero),
        .latency     (latency)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        alu_enable = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        raise_err  = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (!legal || div_by_zero) ? ST_ERR : ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_enable = 1'b1;
                if (cnt_q != '0) begin
                    cnt_dec = 1'b1;
                end else begin
                    capture   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                raise_err = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: every register here, Z pair included, is cleared by the async
    // reset so an aborted op leaves no stale result or pending done behind.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            z_hi   <= '0;
            z_lo   <= '0;
            z_zero <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= capture || raise_err;
            err  <= raise_err;
            if (accept) begin
                op_q  <= op;
                a_q   <= a_in;
                b_q   <= b_in;
                cnt_q <= latency;
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - 1'b1;
            end
            // Error responses leave the Z pair and its zero flag untouched.
            if (capture) begin
                z_hi   <= alu_zhi;
                z_lo   <= alu_zlo;
                z_zero <= ~|{alu_zhi, alu_zlo};
            end
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_ctrl = op_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural ALU drives the Z
// inputs, and an op-level model predicts timing, flags and the Z pair.
module tb_alu_issue_ctrl;

    localparam int WIDTH       = 32;
    localparam int MUL_LATENCY = 1;
    localparam int CNT_W       = 4;

    logic             clk, clr, start;
    logic [4:0]       op;
    logic [WIDTH-1:0] a_in, b_in;
    logic             ready, done, err, z_zero, alu_enable;
    logic [WIDTH-1:0] z_hi, z_lo, alu_a, alu_b, alu_zhi, alu_zlo;
    logic [4:0]       alu_ctrl;

    int n_total = 0;
    int n_pass  = 0;

    logic [WIDTH-1:0] exp_zhi = '0;
    logic [WIDTH-1:0] exp_zlo = '0;
    logic             exp_zz  = 1'b0;

    alu_issue_ctrl #(
        .WIDTH(WIDTH), .MUL_LATENCY(MUL_LATENCY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .ready(ready), .done(done), .err(err), .z_zero(z_zero),
        .z_hi(z_hi), .z_lo(z_lo), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .alu_enable(alu_enable),
        .alu_zhi(alu_zhi), .alu_zlo(alu_zlo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full 64-bit result of an op as {zHI, zLOW}.
    function automatic logic [63:0] alu_fn(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] aa;
        logic [4:0]  s;
        aa = {a, a};
        s  = b[4:0];
        case (o)
            5'd0:  return {32'd0, a + b};
            5'd1:  return {32'd0, a - b};
            5'd2:  return 64'(a) * 64'(b);
            5'd3:  return (b == 0) ? 64'd0 : {a % b, a / b};
            5'd4:  return {32'd0, a >> s};
            5'd5:  return {32'd0, a << s};
            5'd6:  return {32'd0, 32'(aa >> s)};
            5'd7:  begin aa = aa << s; return {32'd0, aa[63:32]}; end
            5'd8:  return {32'd0, a & b};
            5'd9:  return {32'd0, a | b};
            5'd10: return {32'd0, -a};
            5'd11: return {32'd0, ~a};
            default: return 64'd0;
        endcase
    endfunction

    // Environment ALU: the multiplier result is registered one clock after
    // its operands, everything else is combinational.
    logic [63:0] mul_q = '0;
    logic [63:0] alu_r;
    always @(posedge clk) mul_q <= 64'(alu_a) * 64'(alu_b);
    always_comb begin
        alu_r = alu_fn(alu_ctrl, alu_a, alu_b);
        if (alu_ctrl == 5'd2) alu_r = mul_q;
        alu_zhi = alu_r[63:32];
        alu_zlo = alu_r[31:0];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one request, walk the predicted latency cycle by cycle and check
    // the done cycle. Returns with the bench in the done cycle.
    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
        bit          is_err;
        int          lat;
        logic [63:0] r;
        is_err = (o > 5'd11) || (o == 5'd3 && b == 0);
        lat    = (!is_err && o == 5'd2) ? MUL_LATENCY : 0;
        check("ready_before", 64'(ready), 64'(1));
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk); #1;
        start = 1'b0; op = 5'($urandom); a_in = $urandom; b_in = $urandom;
        for (int k = 0; k <= lat; k++) begin
            check("done_early", 64'(done), 64'(0));
            check("ready_busy", 64'(ready), 64'(0));
            check("alu_enable", 64'(alu_enable), 64'(!is_err));
            if (!is_err) begin
                check("alu_a_hold", 64'(alu_a), 64'(a));
                check("alu_b_hold", 64'(alu_b), 64'(b));
                check("alu_ctrl_hold", 64'(alu_ctrl), 64'(o));
            end
            if (poke) begin start = 1'b1; op = 5'd0; end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (!is_err) begin
            r       = alu_fn(o, a, b);
            exp_zhi = r[63:32];
            exp_zlo = r[31:0];
            exp_zz  = (r == 64'd0);
        end
        check("done", 64'(done), 64'(1));
        check("err", 64'(err), 64'(is_err));
        check("z_hi", 64'(z_hi), 64'(exp_zhi));
        check("z_lo", 64'(z_lo), 64'(exp_zlo));
        check("z_zero", 64'(z_zero), 64'(exp_zz));
        check("ready_done", 64'(ready), 64'(1));
        check("enable_off", 64'(alu_enable), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  ro;
        logic [31:0] ra, rb;

        clr = 1'b0; start = 1'b0; op = '0; a_in = '0; b_in = '0;
        #12;
        check("rst_z_hi", 64'(z_hi), 64'(0));
        check("rst_z_lo", 64'(z_lo), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_enable", 64'(alu_enable), 64'(0));
        check("rst_ctrl", 64'(alu_ctrl), 64'(0));
        clr = 1'b1;
        @(posedge clk); #1;

        run_op(5'd0, 32'd5, 32'd7, 1'b0);                  // add
        run_op(5'd3, 32'd100, 32'd0, 1'b0);                // divide by zero
        run_op(5'd20, 32'd1, 32'd2, 1'b0);                 // illegal opcode
        run_op(5'd2, 32'h0001_0000, 32'h0001_0000, 1'b0);  // mul into z_hi
        run_op(5'd1, 32'd9, 32'd9, 1'b0);                  // zero result
        run_op(5'd9, 32'd4, 32'd1, 1'b0);                  // back-to-back or
        run_op(5'd2, 32'd1234, 32'd5678, 1'b1);            // start while busy
        @(posedge clk); #1;
        check("no_second_done", 64'(done), 64'(0));
        check("no_second_exec", 64'(alu_enable), 64'(0));

        // Reset during EXEC of a mul.
        start = 1'b1; op = 5'd2; a_in = 32'd77; b_in = 32'd99;
        @(posedge clk); #1;
        start = 1'b0;
        check("mid_enable", 64'(alu_enable), 64'(1));
        clr = 1'b0;
        #1;
        exp_zhi = '0; exp_zlo = '0; exp_zz = 1'b0;
        check("abort_z_hi", 64'(z_hi), 64'(0));
        check("abort_z_lo", 64'(z_lo), 64'(0));
        check("abort_enable", 64'(alu_enable), 64'(0));
        check("abort_a", 64'(alu_a), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        #3 clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("abort_no_done", 64'(done), 64'(0));
        end
        run_op(5'd0, 32'd40, 32'd2, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ro = 5'($urandom_range(0, 13));
            if (ro > 5'd11) ro = 5'($urandom_range(12, 31));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        check("final_done_clear", 64'(done), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
